// File: rtl/edcoder_pkg.sv
// Shared types and helpers for the keypad-to-BCD encoder.
package edcoder_pkg;

    localparam int unsigned NUM_KEYS = 10;
    localparam int unsigned CODE_W   = 4;

    localparam logic [CODE_W-1:0] CODE_ERR = 4'hF;

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StRelease
    } state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              err;
    } enc_t;

    // Single set bit yields its index; any multi-key vector yields CODE_ERR with err set.
    function automatic enc_t onehot_to_bcd(input logic [NUM_KEYS-1:0] keys);
        enc_t        r;
        int unsigned n;
        r.code = '0;
        r.err  = 1'b0;
        n      = 0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (keys[k]) begin
                n++;
                r.code = CODE_W'(k);
            end
        end
        if (n > 1) begin
            r.code = CODE_ERR;
            r.err  = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/key_sync_debounce.sv
// Two-flop synchroniser and debounce counter; stable_o follows the synchronised
// vector once it has held unchanged for DEBOUNCE_CYCLES cycles.
module key_sync_debounce
    import edcoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned WIDTH           = NUM_KEYS
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] stable_o
);

    localparam logic [7:0] CntMax = 8'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d;
    logic [7:0]       cnt_q, cnt_d;

    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        // sync1 != sync2 means the synchronised vector changes on this edge.
        if (sync1_q != sync2_q) begin
            cnt_d = '0;
        end else if (cnt_q != CntMax) begin
            cnt_d = cnt_q + 8'd1;
        end
        if (cnt_d == CntMax) begin
            stable_d = sync2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/keypad_bcd_encoder.sv
// Debounced 10-key to BCD encoder with a valid/ready output; one event per press.
// Define ENCODER_AUTOREPEAT_EN to re-issue a held single key every REPEAT_CYCLES.
module keypad_bcd_encoder
    import edcoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
`ifdef ENCODER_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES = 16
`endif
) (
    input  logic                iCLK,
    input  logic                iRSTn,
    input  logic [NUM_KEYS-1:0] iIN,
    input  logic                iREADY,
    output logic [CODE_W-1:0]   oCODE,
    output logic                oVALID,
    output logic                oERR,
    output logic                oKEY_DOWN
);

    logic [NUM_KEYS-1:0] stable;
    enc_t                enc;
    state_e              state_q, state_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                err_q, err_d;
    logic                valid_q, valid_d;
    logic                key_down_q;
`ifdef ENCODER_AUTOREPEAT_EN
    logic [NUM_KEYS-1:0] key_q, key_d;
    logic [15:0]         rep_q, rep_d;
`endif

    key_sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .WIDTH          (NUM_KEYS)
    ) u_debounce (
        .clk_i   (iCLK),
        .rst_ni  (iRSTn),
        .raw_i   (iIN),
        .stable_o(stable)
    );

    always_comb begin
        enc     = onehot_to_bcd(stable);
        state_d = state_q;
        code_d  = code_q;
        err_d   = err_q;
        valid_d = valid_q;
`ifdef ENCODER_AUTOREPEAT_EN
        key_d   = key_q;
        rep_d   = rep_q;
`endif
        case (state_q)
            StIdle: begin
                if (stable != '0) begin
                    state_d = StHold;
                    code_d  = enc.code;
                    err_d   = enc.err;
                    valid_d = 1'b1;
`ifdef ENCODER_AUTOREPEAT_EN
                    key_d   = stable;
`endif
                end
            end
            StHold: begin
                if (iREADY) begin
                    state_d = StRelease;
                    valid_d = 1'b0;
`ifdef ENCODER_AUTOREPEAT_EN
                    // The accepting edge counts as the first held cycle.
                    rep_d   = 16'd1;
`endif
                end
            end
            StRelease: begin
                if (stable == '0) begin
                    state_d = StIdle;
`ifdef ENCODER_AUTOREPEAT_EN
                end else if (!err_q && stable == key_q) begin
                    if (rep_q == 16'(REPEAT_CYCLES - 1)) begin
                        state_d = StHold;
                        valid_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 16'd1;
                    end
                end else begin
                    rep_d = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q    <= StIdle;
            code_q     <= '0;
            err_q      <= 1'b0;
            valid_q    <= 1'b0;
            key_down_q <= 1'b0;
`ifdef ENCODER_AUTOREPEAT_EN
            key_q      <= '0;
            rep_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            err_q      <= err_d;
            valid_q    <= valid_d;
            key_down_q <= |stable;
`ifdef ENCODER_AUTOREPEAT_EN
            key_q      <= key_d;
            rep_q      <= rep_d;
`endif
        end
    end

    assign oCODE     = code_q;
    assign oERR      = err_q;
    assign oVALID    = valid_q;
    assign oKEY_DOWN = key_down_q;

endmodule

// File: tb/tb_keypad_bcd_encoder.sv
// Self-checking bench for keypad_bcd_encoder: directed scenarios plus random key
// traffic against a cycle-level behavioural model of the debounce and handshake rules.
module tb_keypad_bcd_encoder;

    localparam int D   = 4;
    localparam int LAT = D + 3;  // step index at which oVALID is first visible
`ifdef ENCODER_AUTOREPEAT_EN
    localparam int REP = 16;
`endif

    logic       iCLK   = 1'b0;
    logic       iRSTn  = 1'b0;
    logic       iREADY = 1'b0;
    logic [9:0] iIN    = '0;
    logic [3:0] oCODE;
    logic       oVALID, oERR, oKEY_DOWN;

    int passed = 0;
    int total  = 0;

    logic [9:0] m_s, m_key;
    logic       m_valid, m_busy, m_err, m_kd;
    logic [3:0] m_code;
    int         m_rep;
    logic [9:0] hist[$];

    keypad_bcd_encoder #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .iCLK     (iCLK),
        .iRSTn    (iRSTn),
        .iIN      (iIN),
        .iREADY   (iREADY),
        .oCODE    (oCODE),
        .oVALID   (oVALID),
        .oERR     (oERR),
        .oKEY_DOWN(oKEY_DOWN)
    );

    always #5 iCLK = ~iCLK;

    function automatic logic [4:0] ref_encode(input logic [9:0] v);
        if ($countones(v) == 1) return {4'($clog2(v)), 1'b0};
        return {4'hF, 1'b1};
    endfunction

    task automatic model_reset();
        m_s = '0; m_key = '0; m_valid = 0; m_busy = 0; m_err = 0; m_kd = 0;
        m_code = '0; m_rep = 0;
        hist.delete();
        for (int i = 0; i < D + 1; i++) hist.push_back('0);
    endtask

    // S takes a raw value once D+1 consecutive edges sampled it; the pipeline
    // delay falls out of excluding the current edge's sample.
    task automatic model_edge(input logic [9:0] in, input logic rdy);
        logic [9:0] s_old;
        logic       same;
        logic [4:0] e;
        s_old = m_s;
        if (m_valid) begin
            if (rdy) begin m_valid = 0; m_rep = 1; end
        end else if (m_busy) begin
            if (s_old == '0) m_busy = 0;
`ifdef ENCODER_AUTOREPEAT_EN
            else if (!m_err && s_old == m_key) begin
                if (m_rep == REP - 1) m_valid = 1;
                else m_rep++;
            end else m_rep = 0;
`endif
        end else if (s_old != '0) begin
            e = ref_encode(s_old);
            m_valid = 1; m_busy = 1; m_code = e[4:1]; m_err = e[0]; m_key = s_old;
        end
        m_kd = |s_old;
        same = 1;
        foreach (hist[i]) if (hist[i] !== hist[0]) same = 0;
        if (same) m_s = hist[0];
        hist.push_back(in);
        void'(hist.pop_front());
    endtask

    task automatic step(input logic [9:0] in, input logic rdy);
        iIN = in;
        iREADY = rdy;
        @(posedge iCLK);
        model_edge(in, rdy);
        #1;
    endtask

    task automatic test_reset();
        iRSTn = 0; iIN = '0; iREADY = 0;
        repeat (3) @(posedge iCLK);
        #1;
        total++;
        if ({oVALID, oERR, oKEY_DOWN, oCODE} !== 7'b0)
            $display("FAIL reset_hold: got v=%b e=%b kd=%b c=%h want all 0",
                     oVALID, oERR, oKEY_DOWN, oCODE);
        else passed++;
        iRSTn = 1;
        model_reset();
        repeat (3) step('0, 0);
        total++;
        if ({oVALID, oERR, oKEY_DOWN, oCODE} !== 7'b0)
            $display("FAIL reset_release: got v=%b e=%b kd=%b c=%h want all 0",
                     oVALID, oERR, oKEY_DOWN, oCODE);
        else passed++;
    endtask

    task automatic test_single_key();
        int first = -1;
        int nv = 0;
        for (int k = 1; k <= 26; k++) begin
            step((k <= 12) ? 10'h008 : 10'h000, 1);
            total++;
            if ({oVALID, oCODE, oERR, oKEY_DOWN} !== {m_valid, m_code, m_err, m_kd})
                $display("FAIL single_key k=%0d: got v=%b c=%h e=%b kd=%b want v=%b c=%h e=%b kd=%b",
                         k, oVALID, oCODE, oERR, oKEY_DOWN, m_valid, m_code, m_err, m_kd);
            else passed++;
            if (oVALID) begin
                nv++;
                if (first < 0) first = k;
            end
        end
        total++;
        if (first !== LAT) $display("FAIL single_latency: got %0d want %0d", first, LAT);
        else passed++;
        total++;
        if (nv !== 1) $display("FAIL single_once: got %0d valid cycles want 1", nv);
        else passed++;
    endtask

    task automatic test_hold_no_ready();
        int nv_hold = 0;
        int nv_after = 0;
        for (int k = 1; k <= 30; k++) begin
            step((k <= 10) ? 10'h200 : 10'h000, k > 20);
            total++;
            if ({oVALID, oCODE, oERR, oKEY_DOWN} !== {m_valid, m_code, m_err, m_kd})
                $display("FAIL hold k=%0d: got v=%b c=%h e=%b kd=%b want v=%b c=%h e=%b kd=%b",
                         k, oVALID, oCODE, oERR, oKEY_DOWN, m_valid, m_code, m_err, m_kd);
            else passed++;
            if (oVALID && k <= 20) nv_hold++;
            if (oVALID && k > 20) nv_after++;
            if (oVALID && oCODE !== 4'd9) begin
                total++;
                $display("FAIL hold_code k=%0d: got %h want 9", k, oCODE);
            end
        end
        total++;
        if (nv_hold !== 20 - LAT + 1)
            $display("FAIL hold_valid: got %0d want %0d", nv_hold, 20 - LAT + 1);
        else passed++;
        total++;
        if (nv_after !== 0) $display("FAIL hold_accept_once: got %0d want 0", nv_after);
        else passed++;
    endtask

    task automatic test_multi_key();
        for (int k = 1; k <= 25; k++) begin
            step((k <= 13) ? 10'h011 : 10'h000, k > 10);
            total++;
            if ({oVALID, oCODE, oERR, oKEY_DOWN} !== {m_valid, m_code, m_err, m_kd})
                $display("FAIL multi k=%0d: got v=%b c=%h e=%b kd=%b want v=%b c=%h e=%b kd=%b",
                         k, oVALID, oCODE, oERR, oKEY_DOWN, m_valid, m_code, m_err, m_kd);
            else passed++;
            if (k == 10) begin
                total++;
                if ({oVALID, oCODE, oERR} !== {1'b1, 4'hF, 1'b1})
                    $display("FAIL multi_err: got v=%b c=%h e=%b want v=1 c=f e=1",
                             oVALID, oCODE, oERR);
                else passed++;
            end
        end
    endtask

    task automatic test_bounce();
        logic any_v = 0;
        logic any_kd = 0;
        for (int k = 1; k <= 15; k++) begin
            step((k <= 3) ? 10'h002 : 10'h000, 1);
            any_v  |= oVALID;
            any_kd |= oKEY_DOWN;
        end
        total++;
        if (any_v !== 1'b0) $display("FAIL bounce_valid: got %b want 0", any_v);
        else passed++;
        total++;
        if (any_kd !== 1'b0) $display("FAIL bounce_keydown: got %b want 0", any_kd);
        else passed++;
    endtask

    task automatic test_reset_in_hold();
        int nv = 0;
        for (int k = 1; k <= 9; k++) step(10'h020, 0);
        total++;
        if ({oVALID, oCODE} !== {1'b1, 4'd5})
            $display("FAIL rst_pre: got v=%b c=%h want v=1 c=5", oVALID, oCODE);
        else passed++;
        iRSTn = 0;
        #1;
        total++;
        if ({oVALID, oKEY_DOWN} !== 2'b00)
            $display("FAIL rst_async: got v=%b kd=%b want 0 0", oVALID, oKEY_DOWN);
        else passed++;
        @(posedge iCLK);
        @(posedge iCLK);
        #1;
        iRSTn = 1;
        model_reset();
        for (int k = 1; k <= 27; k++) begin
            step((k <= 15) ? 10'h020 : 10'h000, 1);
            total++;
            if ({oVALID, oCODE, oERR, oKEY_DOWN} !== {m_valid, m_code, m_err, m_kd})
                $display("FAIL rst_after k=%0d: got v=%b c=%h e=%b kd=%b want v=%b c=%h e=%b kd=%b",
                         k, oVALID, oCODE, oERR, oKEY_DOWN, m_valid, m_code, m_err, m_kd);
            else passed++;
            if (oVALID) nv++;
        end
        total++;
        if (nv !== 1) $display("FAIL rst_one_event: got %0d want 1", nv);
        else passed++;
    endtask

    task automatic test_random();
        logic [9:0] pat;
        int r, len;
        for (int seg = 0; seg < 150; seg++) begin
            r = $urandom_range(0, 9);
            pat = '0;
            if (r >= 4 && r < 8) pat[$urandom_range(0, 9)] = 1'b1;
            else if (r >= 8) pat = 10'($urandom_range(1, 1023));
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                step(pat, 1'($urandom_range(0, 1)));
                total++;
                if ({oVALID, oCODE, oERR, oKEY_DOWN} !== {m_valid, m_code, m_err, m_kd})
                    $display("FAIL random seg=%0d: got v=%b c=%h e=%b kd=%b want v=%b c=%h e=%b kd=%b",
                             seg, oVALID, oCODE, oERR, oKEY_DOWN, m_valid, m_code, m_err, m_kd);
                else passed++;
            end
        end
        repeat (15) step('0, 1);
    endtask

`ifdef ENCODER_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int pos[$];
        for (int k = 1; k <= 90; k++) begin
            step((k <= 60) ? 10'h040 : 10'h000, 1);
            total++;
            if ({oVALID, oCODE, oERR, oKEY_DOWN} !== {m_valid, m_code, m_err, m_kd})
                $display("FAIL repeat k=%0d: got v=%b c=%h e=%b kd=%b want v=%b c=%h e=%b kd=%b",
                         k, oVALID, oCODE, oERR, oKEY_DOWN, m_valid, m_code, m_err, m_kd);
            else passed++;
            if (oVALID) pos.push_back(k);
        end
        total++;
        if (pos.size() !== 4) $display("FAIL repeat_count: got %0d want 4", pos.size());
        else passed++;
        foreach (pos[i]) begin
            total++;
            if (pos[i] !== LAT + i * REP)
                $display("FAIL repeat_pos%0d: got %0d want %0d", i, pos[i], LAT + i * REP);
            else passed++;
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single_key();
        test_hold_no_ready();
        test_multi_key();
        test_bounce();
        test_reset_in_hold();
        test_random();
`ifdef ENCODER_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
